// File: rtl/d_imm_extend_pipe.sv
// Decode-stage immediate extender: zero / sign / upper / branch-offset modes,
// registered output with valid/ready handshake and a one-entry skid buffer.
module d_imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [IN_W-1:0]  i_data_immD,
    input  logic [1:0]       i_con_mode,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_data_immD
);

    localparam int PAD_W = OUT_W - IN_W;

    generate
        if (OUT_W <= IN_W) begin : g_bad_width
            $error("d_imm_extend_pipe: OUT_W must be greater than IN_W");
        end
    endgenerate

    // Handshake: a beat moves on a rising edge when valid and ready are both
    // high on that side. o_ready depends only on state, never on i_ready.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // r_state is the observable FSM state for checkers.
    state_t           r_state;
    state_t           w_state_nxt;
    logic [OUT_W-1:0] r_out_d;
    logic [OUT_W-1:0] r_sk_d;
    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] w_sext;
    logic             w_acc;
    logic             w_xfer;
    logic             w_load_out;
    logic             w_load_sk;
    logic             w_out_from_sk;

    always_comb begin
        w_sext = {{PAD_W{i_data_immD[IN_W-1]}}, i_data_immD};
        w_ext  = '0;
        case (i_con_mode)
            2'b00:   w_ext = {{PAD_W{1'b0}}, i_data_immD};
            2'b01:   w_ext = w_sext;
            2'b10:   w_ext = {i_data_immD, {PAD_W{1'b0}}};
            default: w_ext = w_sext << 2;
        endcase
    end

    assign o_valid     = (r_state != ST_EMPTY);
    assign o_ready     = (r_state != ST_FULL);
    assign o_data_immD = r_out_d;
    assign w_acc       = i_valid & o_ready;
    assign w_xfer      = o_valid & i_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_sk     = 1'b0;
        w_out_from_sk = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    w_state_nxt = ST_ONE;
                    w_load_out  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_acc && w_xfer) begin
                    w_load_out = 1'b1;
                end else if (w_acc) begin
                    w_state_nxt = ST_FULL;
                    w_load_sk   = 1'b1;
                end else if (w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    w_state_nxt   = ST_ONE;
                    w_load_out    = 1'b1;
                    w_out_from_sk = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // Flush drops everything, including this cycle's beats; data regs keep stale values.
        if (i_flush) begin
            w_state_nxt   = ST_EMPTY;
            w_load_out    = 1'b0;
            w_load_sk     = 1'b0;
            w_out_from_sk = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
            r_out_d <= '0;
            r_sk_d  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_out) begin
                r_out_d <= w_out_from_sk ? r_sk_d : w_ext;
            end
            if (w_load_sk) begin
                r_sk_d <= w_ext;
            end
        end
    end

endmodule

// File: tb/tb_d_imm_extend_pipe.sv
// Directed and randomised bench for d_imm_extend_pipe (IN_W=16, OUT_W=32).
module tb_d_imm_extend_pipe;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_data_immD;
    logic [1:0]  i_con_mode;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data_immD;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    d_imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data_immD (i_data_immD),
        .i_con_mode  (i_con_mode),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data_immD (o_data_immD)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] model_ext(input logic [15:0] d, input logic [1:0] m);
        logic [31:0] s;
        s = 32'($signed(d));
        case (m)
            2'b00:   return {16'h0000, d};
            2'b01:   return s;
            2'b10:   return {d, 16'h0000};
            default: return s * 32'd4;
        endcase
    endfunction

    task automatic chk_out(input string name, input logic v, input logic rdy, input logic [31:0] d, input logic chk_d);
        checks++;
        if (o_valid !== v || o_ready !== rdy || (chk_d && o_data_immD !== d)) begin
            errors++;
            $display("FAIL %s: got valid=%b ready=%b data=%h, want valid=%b ready=%b data=%h",
                     name, o_valid, o_ready, o_data_immD, v, rdy, d);
        end
    endtask

    task automatic fill_full(input logic [15:0] a, input logic [15:0] b);
        i_ready = 1'b0; i_valid = 1'b1; i_con_mode = 2'b00;
        i_data_immD = a; step();
        i_data_immD = b; step();
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        i_data_immD = 16'h0; i_con_mode = 2'b00;
        step(); step();
        i_rst = 1'b0;
        chk_out("reset_state", 1'b0, 1'b1, 32'h0, 1'b1);
    endtask

    task automatic test_modes();
        logic [15:0] vd[5] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h4000};
        logic [1:0]  vm[5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11};
        logic [31:0] ve[5] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC, 32'h00010000};
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1; i_data_immD = vd[i]; i_con_mode = vm[i];
            step();
            chk_out($sformatf("mode_vec%0d", i), 1'b1, 1'b1, ve[i], 1'b1);
        end
        i_valid = 1'b0; i_data_immD = 16'hxxxx;
        step();
        chk_out("modes_drain", 1'b0, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0; i_valid = 1'b1; i_con_mode = 2'b00;
        i_data_immD = 16'h0001; step();
        chk_out("bp_first_accept", 1'b1, 1'b1, 32'h1, 1'b1);
        i_data_immD = 16'h0002; step();
        chk_out("bp_second_accept", 1'b1, 1'b0, 32'h1, 1'b1);
        i_data_immD = 16'h0003;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("bp_stable%0d", i), 1'b1, 1'b0, 32'h1, 1'b1);
        end
        i_ready = 1'b1; step();
        chk_out("bp_out2", 1'b1, 1'b1, 32'h2, 1'b1);
        step();
        i_valid = 1'b0;
        chk_out("bp_out3", 1'b1, 1'b1, 32'h3, 1'b1);
        step();
        chk_out("bp_drain", 1'b0, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic test_flush();
        fill_full(16'h0010, 16'h0011);
        chk_out("flush_prefill", 1'b1, 1'b0, 32'h10, 1'b1);
        i_flush = 1'b1; i_valid = 1'b1; i_data_immD = 16'h00AA; i_ready = 1'b1;
        step();
        i_flush = 1'b0; i_valid = 1'b0;
        chk_out("flush_full", 1'b0, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("flush_no_aa%0d", i), 1'b0, 1'b1, 32'h0, 1'b0);
        end
        // Flush in ONE with a same-cycle accept: the incoming beat is dropped too.
        i_ready = 1'b0; i_valid = 1'b1; i_data_immD = 16'h0020; step();
        i_flush = 1'b1; i_data_immD = 16'h00BB; step();
        i_flush = 1'b0; i_valid = 1'b0;
        chk_out("flush_one_acc", 1'b0, 1'b1, 32'h0, 1'b0);
        i_ready = 1'b1; step();
        chk_out("flush_one_after", 1'b0, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic test_reset_midstream();
        fill_full(16'h0030, 16'h0031);
        i_rst = 1'b1; step(); i_rst = 1'b0;
        chk_out("rst_midstream", 1'b0, 1'b1, 32'h0, 1'b1);
        fill_full(16'h0040, 16'h0041);
        i_rst = 1'b1; i_flush = 1'b1; step(); i_rst = 1'b0; i_flush = 1'b0;
        chk_out("rst_and_flush", 1'b0, 1'b1, 32'h0, 1'b1);
    endtask

    task automatic test_random();
        logic        acc, xfer, hold;
        logic [31:0] prev_d, exp_d;
        hold = 1'b0; prev_d = '0;
        exp_q.delete();
        for (int c = 0; c < 10000; c++) begin
            if (c < 9980) begin
                i_valid = 1'($urandom_range(0, 1));
                i_ready = ($urandom_range(0, 3) != 0);
            end else begin
                i_valid = 1'b0;
                i_ready = 1'b1;
            end
            i_con_mode  = 2'($urandom_range(0, 3));
            i_data_immD = 16'($urandom_range(0, 65535));
            if (hold) begin
                checks++;
                if (o_valid !== 1'b1 || o_data_immD !== prev_d) begin
                    errors++;
                    $display("FAIL rand_stable cycle %0d: got valid=%b data=%h, want valid=1 data=%h",
                             c, o_valid, o_data_immD, prev_d);
                end
            end
            acc  = i_valid & o_ready;
            xfer = o_valid & i_ready;
            if (xfer) begin
                exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                checks++;
                if (o_data_immD !== exp_d) begin
                    errors++;
                    $display("FAIL rand_data cycle %0d: got %h, want %h", c, o_data_immD, exp_d);
                end
            end
            if (acc) exp_q.push_back(model_ext(i_data_immD, i_con_mode));
            hold   = o_valid & ~i_ready;
            prev_d = o_data_immD;
            step();
        end
        i_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: got queued=%0d valid=%b, want queued=0 valid=0", exp_q.size(), o_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_modes();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
